// File: rtl/amdf_pitch_detector.sv
// AMDF pitch detector: ping-pong sample windows, per-window argmin of D(tau) over [TAU_MIN, TAU_MAX].
// Define AMDF_EARLY_EXIT_EN to stop the sweep at the first deep dip below d_max >> THRESH_SHIFT.
module amdf_pitch_detector #(
    parameter int WINDOW_SIZE  = 2048,
    parameter int TAU_MIN      = 20,
    parameter int TAU_MAX      = 1024,
    parameter int INTEG_LEN    = 1024,
    parameter int THRESH_SHIFT = 3
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic signed [15:0] sample_in,
    input  logic               sample_valid_in,
    output logic [10:0]        tau_out,
    output logic               tau_valid_out,
    output logic               busy_out,
    output logic               overrun_out
);

    localparam int              AW      = $clog2(WINDOW_SIZE);
    localparam int              NW      = $clog2(INTEG_LEN + 3) + 1;
    localparam logic [10:0]     TAU_LO  = 11'(TAU_MIN);
    localparam logic [10:0]     TAU_HI  = 11'(TAU_MAX);
    localparam logic [NW-1:0]   N_ISSUE = NW'(INTEG_LEN);
    localparam logic [NW-1:0]   N_LAST  = NW'(INTEG_LEN + 2);

    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, COMPARE, REPORT} state_t;

    if (TAU_MIN < 1 || TAU_MAX > 2047 || TAU_MIN > TAU_MAX ||
        INTEG_LEN + TAU_MAX > WINDOW_SIZE || THRESH_SHIFT < 0 || THRESH_SHIFT > 31 ||
        (WINDOW_SIZE & (WINDOW_SIZE - 1)) != 0) begin : g_param_check
        $error("amdf_pitch_detector: illegal parameter combination");
    end

    logic signed [15:0] mem0 [2*WINDOW_SIZE];
    logic signed [15:0] mem1 [2*WINDOW_SIZE];
    logic [AW-1:0]      wr_count;
    logic               wr_bank;
    logic               window_done;

    state_t             state;
    logic               rd_bank;
    logic [10:0]        tau;
    logic [10:0]        best_tau;
    logic [31:0]        best_d;
    logic [31:0]        acc;
    logic [NW-1:0]      n;
    logic [2:0]         pipe_v;
    logic [AW:0]        rd_addr0;
    logic [AW:0]        rd_addr1;
    logic signed [15:0] q0_s1, q1_s1, q0_s2, q1_s2;
    logic signed [16:0] diff;
    logic [16:0]        diff_mag;
    logic [16:0]        absdiff_r;
    logic               issue;
    logic               better;
    logic               early;
    logic               finish;
    logic [10:0]        pick_tau;
`ifdef AMDF_EARLY_EXIT_EN
    logic [31:0]        d_max;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_count    <= '0;
            wr_bank     <= 1'b0;
            window_done <= 1'b0;
        end else begin
            window_done <= 1'b0;
            if (sample_valid_in) begin
                if (wr_count == AW'(WINDOW_SIZE - 1)) begin
                    wr_count    <= '0;
                    wr_bank     <= ~wr_bank;
                    window_done <= 1'b1;
                end else begin
                    wr_count <= wr_count + AW'(1);
                end
            end
        end
    end

    // NOTE: the sample RAMs and their output registers carry no reset; reads are qualified by pipe_v.
    always_ff @(posedge clk_in) begin
        if (sample_valid_in) begin
            mem0[{wr_bank, wr_count}] <= sample_in;
            mem1[{wr_bank, wr_count}] <= sample_in;
        end
        q0_s1 <= mem0[rd_addr0];
        q1_s1 <= mem1[rd_addr1];
        q0_s2 <= q0_s1;
        q1_s2 <= q1_s1;
    end

    // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
    always_comb begin
        rd_addr0 = {rd_bank, AW'(n)};
        rd_addr1 = {rd_bank, AW'(n) + AW'(tau)};
        issue    = (state == ACCUM) && (n < N_ISSUE);
        diff     = 17'(q0_s2) - 17'(q1_s2);
        diff_mag = diff[16] ? -diff : diff;
        better   = (tau == TAU_LO) || (acc < best_d);
        early    = 1'b0;
`ifdef AMDF_EARLY_EXIT_EN
        early    = (tau != TAU_LO) && (acc < (d_max >> THRESH_SHIFT));
`endif
        finish   = early || (tau == TAU_HI);
        pick_tau = (better || early) ? tau : best_tau;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state         <= IDLE;
            rd_bank       <= 1'b0;
            tau           <= TAU_LO;
            best_tau      <= TAU_LO;
            best_d        <= '0;
            acc           <= '0;
            n             <= '0;
            pipe_v        <= '0;
            absdiff_r     <= '0;
            tau_out       <= '0;
            tau_valid_out <= 1'b0;
            busy_out      <= 1'b0;
            overrun_out   <= 1'b0;
`ifdef AMDF_EARLY_EXIT_EN
            d_max         <= '0;
`endif
        end else begin
            tau_valid_out <= 1'b0;
            overrun_out   <= window_done && (state != IDLE);
            pipe_v        <= {pipe_v[1:0], issue};
            absdiff_r     <= diff_mag;
            unique case (state)
                IDLE: begin
                    if (window_done) begin
                        // The bank just toggled, so the completed window sits in the other one.
                        rd_bank  <= ~wr_bank;
                        tau      <= TAU_LO;
                        busy_out <= 1'b1;
`ifdef AMDF_EARLY_EXIT_EN
                        d_max    <= '0;
`endif
                        state    <= CLEAR;
                    end
                end
                CLEAR: begin
                    acc   <= '0;
                    n     <= '0;
                    state <= ACCUM;
                end
                ACCUM: begin
                    if (pipe_v[2]) acc <= acc + 32'(absdiff_r);
                    if (n == N_LAST) state <= COMPARE;
                    else             n     <= n + NW'(1);
                end
                COMPARE: begin
                    if (better) begin
                        best_d   <= acc;
                        best_tau <= tau;
                    end
`ifdef AMDF_EARLY_EXIT_EN
                    if (acc > d_max) d_max <= acc;
`endif
                    if (finish) begin
                        tau_out       <= pick_tau;
                        tau_valid_out <= 1'b1;
                        state         <= REPORT;
                    end else begin
                        tau   <= tau + 11'd1;
                        state <= CLEAR;
                    end
                end
                REPORT: begin
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
